// File: rtl/div_pkg.sv
// Shared definitions for the multicycle divider issue/capture stage.
//   state_t   : control FSM encoding (2'd3 is unused and treated as IDLE)
//   CNT_W     : width of the settle counter
//   DBZ_QUOT  : quotient reported for a zero divisor (all ones, truncated by the user)
package div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int CNT_W = 8;
  localparam int MAX_W = 64;

  // Callers cast the result down to their own data width.
  function automatic logic [MAX_W-1:0] DBZ_QUOT();
    return '1;
  endfunction

endpackage

// File: rtl/div_mc_ctrl_div.sv
// Combinational unsigned divider, timed by its user as a multicycle path.
// Ports:
//   a : dividend, unsigned
//   b : divisor, unsigned
//   q : truncated quotient (0 when b is 0; the caller substitutes its own
//       divide-by-zero value)
module div_mc_ctrl_div #(
  parameter int DATAWIDTH = 16
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] q
);

  // Guarded so simulation never sees a divide by zero.
  assign q = (b == '0) ? '0 : (a / b);

endmodule

// File: rtl/div_mc_ctrl.sv
// Multicycle issue/capture stage around the combinational divider.
// Operands are registered on accept and held on the divider inputs for
// LATENCY cycles, then the quotient and divide-by-zero flag are captured
// and offered downstream until taken.
// Ports:
//   Clk       : rising-edge clock
//   Rst       : asynchronous reset, active-low
//   in_valid  : upstream operands valid
//   in_ready  : block accepts operands this cycle
//   a, b      : dividend / divisor, unsigned
//   out_valid : quot/dbz valid
//   out_ready : downstream accepts the result
//   quot      : registered quotient
//   dbz       : divide-by-zero flag for the current result
module div_mc_ctrl
  import div_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int LATENCY   = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] quot,
  output logic                 dbz
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t                 state;
  logic [CNT_W-1:0]       count;
  logic [DATAWIDTH-1:0]   a_r;
  logic [DATAWIDTH-1:0]   b_r;
  logic [DATAWIDTH-1:0]   div_q;
  logic [DATAWIDTH-1:0]   dbz_quot;
  logic                   st_idle;

  assign dbz_quot = DATAWIDTH'(DBZ_QUOT());

  // The unused encoding behaves as IDLE so a corrupted state recovers.
  assign st_idle  = (state != SETTLE) && (state != DONE);

  // Held low during reset so upstream never sees a transfer it would lose.
  assign in_ready = Rst & (st_idle | ((state == DONE) & out_ready));

  div_mc_ctrl_div #(
    .DATAWIDTH(DATAWIDTH)
  ) u_div (
    .a(a_r),
    .b(b_r),
    .q(div_q)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      count     <= '0;
      a_r       <= '0;
      b_r       <= '0;
      quot      <= '0;
      dbz       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        SETTLE: begin
          // a_r/b_r are untouched here: the divider is still settling.
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            quot      <= (b_r == '0) ? dbz_quot : div_q;
            dbz       <= (b_r == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Retiring and accepting on the same edge gives the LATENCY+1 issue period.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              a_r   <= a;
              b_r   <= b;
              count <= CNT_INIT;
              state <= SETTLE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            count <= CNT_INIT;
            state <= SETTLE;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_mc_ctrl.sv
module tb_div_mc_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] quot;
  logic        dbz;

  logic        in_valid1 = 1'b0;
  logic        in_ready1;
  logic [15:0] a1 = '0;
  logic [15:0] b1 = '0;
  logic        out_valid1;
  logic        out_ready1 = 1'b1;
  logic [15:0] quot1;
  logic        dbz1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [16:0] q0[$];
  logic [16:0] q1[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  div_mc_ctrl #(.DATAWIDTH(16), .LATENCY(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .quot(quot), .dbz(dbz)
  );

  div_mc_ctrl #(.DATAWIDTH(16), .LATENCY(1)) dut1 (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .quot(quot1), .dbz(dbz1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors: pop one expected result per output handshake.
  always @(negedge Clk) begin
    if (Rst && out_valid && out_ready) begin
      n_checks++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got quot=0x%0h dbz=%0b with nothing expected", quot, dbz);
      end else begin
        logic [16:0] e;
        e = q0.pop_front();
        if ({quot, dbz} !== e) begin
          n_fail++;
          $display("FAIL result: got quot=0x%0h dbz=%0b expected quot=0x%0h dbz=%0b",
                   quot, dbz, e[16:1], e[0]);
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (Rst && out_valid1 && out_ready1) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result_lat1: got quot=0x%0h dbz=%0b", quot1, dbz1);
      end else begin
        logic [16:0] e;
        e = q1.pop_front();
        if ({quot1, dbz1} !== e) begin
          n_fail++;
          $display("FAIL result_lat1: got quot=0x%0h dbz=%0b expected quot=0x%0h dbz=%0b",
                   quot1, dbz1, e[16:1], e[0]);
        end
      end
    end
  end

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] eq, input logic ed, input bit push,
                       output int acc_cyc);
    int t;
    t = 0;
    in_valid = 1'b1;
    a = ia;
    b = ib;
    @(negedge Clk);
    while (!in_ready && t < 200) begin
      @(negedge Clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=0 expected 1 within 200 cycles");
    end
    if (push) q0.push_back({eq, ed});
    @(posedge Clk);
    acc_cyc = cyc;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q0.size() != 0 && t < 100) begin
      @(posedge Clk);
      t++;
    end
    #1;
    chk("drain_pending", q0.size(), 0);
  endtask

  initial begin
    int c0, c[4];
    int t;

    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quot", quot, 0);
    chk("rst_dbz", dbz, 0);
    repeat (2) @(posedge Clk);
    #3 Rst = 1'b1;
    @(posedge Clk); #1;
    chk("idle_in_ready", in_ready, 1);

    // Basic: 100/7 with latency timing
    issue(16'd100, 16'd7, 16'd14, 1'b0, 1'b1, c0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge Clk); #1;
      chk("settle_in_ready", in_ready, 0);
      chk("settle_out_valid", out_valid, 0);
    end
    @(posedge Clk); #1;
    chk("basic_out_valid", out_valid, 1);
    chk("basic_quot", quot, 14);
    drain();

    // Divide by zero, then a genuine all-ones quotient
    issue(16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1'b1, c0);
    issue(16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b1, c0);
    drain();

    // Back-to-back with out_ready held high
    issue(16'd50,    16'd5,   16'd10,  1'b0, 1'b1, c[0]);
    issue(16'd7,     16'd8,   16'd0,   1'b0, 1'b1, c[1]);
    issue(16'd65535, 16'd255, 16'd257, 1'b0, 1'b1, c[2]);
    issue(16'd1,     16'd1,   16'd1,   1'b0, 1'b1, c[3]);
    for (int k = 1; k < 4; k++) chk("b2b_period", c[k] - c[k-1], 5);
    drain();

    // Backpressure: result held while new operands wait
    out_ready = 1'b0;
    issue(16'd20, 16'd4, 16'd5, 1'b0, 1'b1, c0);
    t = 0;
    while (!out_valid && t < 20) begin
      @(posedge Clk); #1;
      t++;
    end
    chk("bp_out_valid_rise", out_valid, 1);
    in_valid = 1'b1;
    a = 16'd9;
    b = 16'd3;
    repeat (6) begin
      @(posedge Clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_quot", quot, 5);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    issue(16'd9, 16'd3, 16'd3, 1'b0, 1'b1, c0);
    drain();

    // Reset in the middle of SETTLE
    issue(16'd40, 16'd4, 16'd10, 1'b0, 1'b0, c0);
    @(posedge Clk); #1;
    @(posedge Clk); #2;
    Rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_quot", quot, 0);
    chk("midrst_in_ready", in_ready, 0);
    repeat (2) @(posedge Clk);
    #3 Rst = 1'b1;
    repeat (8) @(posedge Clk);
    #1;
    chk("midrst_no_output", out_valid, 0);
    issue(16'd40, 16'd4, 16'd10, 1'b0, 1'b1, c0);
    drain();

    // LATENCY=1 instance
    in_valid1 = 1'b1;
    a1 = 16'd200;
    b1 = 16'd10;
    chk("lat1_in_ready_idle", in_ready1, 1);
    q1.push_back({16'd20, 1'b0});
    @(posedge Clk); #1;
    a1 = 16'd9;
    b1 = 16'd3;
    q1.push_back({16'd3, 1'b0});
    chk("lat1_settle_valid", out_valid1, 0);
    chk("lat1_settle_ready", in_ready1, 0);
    @(posedge Clk); #1;
    chk("lat1_out_valid", out_valid1, 1);
    chk("lat1_quot", quot1, 20);
    chk("lat1_overlap_ready", in_ready1, 1);
    @(posedge Clk); #1;
    in_valid1 = 1'b0;
    @(posedge Clk); #1;
    chk("lat1_out_valid2", out_valid1, 1);
    chk("lat1_quot2", quot1, 3);
    repeat (3) @(posedge Clk);
    #1;
    chk("lat1_drain", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
